// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI power-up configuration sequencer.
// SPI_CFG_GAP_EN adds the inter-word GAP state to the state encoding.
package spi_cfg_pkg;

  localparam int unsigned SPI_WORD_W    = 40;
  localparam int unsigned SPI_CFG_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_FETCH,
    S_PRESENT,
`ifdef SPI_CFG_GAP_EN
    S_GAP,
`endif
    S_DONE
  } spi_cfg_state_t;

  function automatic logic state_is_busy(input spi_cfg_state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/spi_cfg_delay_counter.sv
// Loadable down-counter shared by the reset-low, reset-wait and gap phases.
// o_zero is registered and is high during the final counted cycle.
module spi_cfg_delay_counter
  import spi_cfg_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic [SPI_CFG_CNT_W-1:0] i_load_val,
  input  logic                     i_en,
  output logic                     o_zero
);

  logic [SPI_CFG_CNT_W-1:0] r_cnt;
  logic                     r_zero;

  // Flag is computed one cycle early so the FSM can leave on the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_zero <= (i_load_val == SPI_CFG_CNT_W'(1));
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - SPI_CFG_CNT_W'(1);
      r_zero <= (r_cnt == SPI_CFG_CNT_W'(2));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// RF chip power-up sequencer: chip reset timing, then ROM words to the SPI master.
// Define SPI_CFG_GAP_EN to insert GAP_CYCLES idle cycles between words.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter  int unsigned NUM_WORDS         = 16,
  parameter  int unsigned WORD_W            = SPI_WORD_W,
  parameter  int unsigned RESET_LOW_CYCLES  = 2000,
  parameter  int unsigned RESET_WAIT_CYCLES = 200,
  parameter  int unsigned GAP_CYCLES        = 4,
  localparam int unsigned IDX_W             = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              xreset_n,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      CNT_MAX  = (1 << SPI_CFG_CNT_W) - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  if ((NUM_WORDS < 1) || (RESET_LOW_CYCLES < 1) || (RESET_LOW_CYCLES > CNT_MAX) ||
      (RESET_WAIT_CYCLES < 1) || (RESET_WAIT_CYCLES > CNT_MAX) ||
      (GAP_CYCLES < 1) || (GAP_CYCLES > CNT_MAX)) begin : g_param_check
    $error("spi_cfg_sequencer: parameter out of range");
  end

  spi_cfg_state_t      r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_rom_addr;
  logic                r_xreset_n;
  logic                r_word_valid;
  logic [WORD_W-1:0]   r_word_data;
  logic                r_busy;
  logic                r_done;

  spi_cfg_state_t             w_state_nxt;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [IDX_W-1:0]           w_rom_addr_nxt;
  logic                       w_xreset_n_nxt;
  logic                       w_word_valid_nxt;
  logic [WORD_W-1:0]          w_word_data_nxt;
  logic                       w_cnt_load;
  logic [SPI_CFG_CNT_W-1:0]   w_cnt_load_val;
  logic                       w_cnt_en;
  logic                       w_cnt_zero;

  spi_cfg_delay_counter u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_rom_addr   <= '0;
      r_xreset_n   <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_rom_addr   <= w_rom_addr_nxt;
      r_xreset_n   <= w_xreset_n_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_word_data  <= w_word_data_nxt;
      r_busy       <= state_is_busy(w_state_nxt);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // rom_addr runs one word ahead so the synchronous ROM output is ready when FETCH captures it.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_rom_addr_nxt   = r_rom_addr;
    w_xreset_n_nxt   = r_xreset_n;
    w_word_valid_nxt = r_word_valid;
    w_word_data_nxt  = r_word_data;
    w_cnt_load       = 1'b0;
    w_cnt_load_val   = '0;
    w_cnt_en         = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_RST_LOW;
          w_idx_nxt      = '0;
          w_rom_addr_nxt = '0;
          w_xreset_n_nxt = 1'b0;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = SPI_CFG_CNT_W'(RESET_LOW_CYCLES);
        end
      end
      S_RST_LOW: begin
        w_cnt_en = 1'b1;
        if (w_cnt_zero) begin
          w_state_nxt    = S_RST_WAIT;
          w_xreset_n_nxt = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = SPI_CFG_CNT_W'(RESET_WAIT_CYCLES);
        end
      end
      S_RST_WAIT: begin
        w_cnt_en = 1'b1;
        if (w_cnt_zero) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt      = S_PRESENT;
        w_word_data_nxt  = rom_data;
        w_word_valid_nxt = 1'b1;
        w_rom_addr_nxt   = (r_idx == LAST_IDX) ? r_idx : r_idx + IDX_W'(1);
      end
      S_PRESENT: begin
        if (r_word_valid && word_ready) begin
          w_word_valid_nxt = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
`ifdef SPI_CFG_GAP_EN
            w_state_nxt    = S_GAP;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = SPI_CFG_CNT_W'(GAP_CYCLES);
`else
            w_state_nxt = S_FETCH;
`endif
          end
        end
      end
`ifdef SPI_CFG_GAP_EN
      S_GAP: begin
        w_cnt_en = 1'b1;
        if (w_cnt_zero) w_state_nxt = S_FETCH;
      end
`endif
      default: begin
        w_state_nxt      = S_IDLE;
        w_word_valid_nxt = 1'b0;
        w_xreset_n_nxt   = 1'b0;
      end
    endcase
  end

  assign xreset_n   = r_xreset_n;
  assign rom_addr   = r_rom_addr;
  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer: expected words queued by stimulus, popped on handshake.
module tb_spi_cfg_sequencer;

`ifdef SPI_CFG_GAP_EN
  localparam int PER = 2 + 4;
`else
  localparam int PER = 2;
`endif

  typedef struct {
    logic [39:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        xreset_n;
  logic [3:0]  rom_addr;
  logic [39:0] rom_data;
  logic        word_valid;
  logic [39:0] word_data;
  logic        word_ready;
  logic        busy;
  logic        done;

  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  exp_t sb[$];
  exp_t mon_e;

  spi_cfg_sequencer #(
    .NUM_WORDS         (16),
    .WORD_W            (40),
    .RESET_LOW_CYCLES  (2000),
    .RESET_WAIT_CYCLES (200),
    .GAP_CYCLES        (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .xreset_n   (xreset_n),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] rom_word(input int i);
    return 40'hC3_5A00_0000 + 40'(i);
  endfunction

  // Synchronous ROM: data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - t0);
    end
  endtask

  // Monitor: compare every handshake against the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!reset && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h with nothing expected", word_data);
      end else begin
        mon_e = sb.pop_front();
        chk("word_data", 64'(word_data), 64'(mon_e.data));
        if (mon_e.cyc >= 0) chk("word_cycle", 64'(cyc - t0), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_to(input int k);
    while ((cyc - t0) < k) @(negedge clk);
  endtask

  // Returns at the negedge of cycle 1 (start sampled at edge 0).
  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_timed();
    int bad;
    for (int i = 0; i < 16; i++) sb.push_back('{data: rom_word(i), cyc: 2202 + PER * i});
    start_seq();
    chk("xrst_low_c1", 64'(xreset_n), 64'(0));
    chk("busy_c1", 64'(busy), 64'(1));
    bad = 0;
    for (int k = 2; k <= 2000; k++) begin
      wait_to(k);
      if (xreset_n !== 1'b0) bad++;
    end
    chk("xrst_low_window", 64'(bad), 64'(0));
    wait_to(2001);
    chk("xrst_high_2001", 64'(xreset_n), 64'(1));
    bad = 0;
    for (int k = 2001; k <= 2200; k++) begin
      wait_to(k);
      if (word_valid !== 1'b0 || xreset_n !== 1'b1) bad++;
    end
    chk("rst_wait_window", 64'(bad), 64'(0));
    wait_to(2201);
    chk("fetch_rom_addr", 64'(rom_addr), 64'(0));
    chk("fetch_no_valid", 64'(word_valid), 64'(0));
    wait_to(2202);
    chk("first_valid", 64'(word_valid), 64'(1));
    wait_to(2202 + 15 * PER + 1);
    chk("done_after_last", 64'(done), 64'(1));
    chk("busy_after_last", 64'(busy), 64'(0));
    chk("valid_after_last", 64'(word_valid), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic seq_stall();
    int v3, bad;
    v3 = 2202 + 3 * PER;
    for (int i = 0; i < 3; i++) sb.push_back('{data: rom_word(i), cyc: 2202 + PER * i});
    sb.push_back('{data: rom_word(3), cyc: v3 + 49});
    for (int i = 4; i < 16; i++) sb.push_back('{data: rom_word(i), cyc: v3 + 49 + PER * (i - 3)});
    start_seq();
    chk("restart_xrst_low", 64'(xreset_n), 64'(0));
    chk("restart_done_clr", 64'(done), 64'(0));
    wait_to(2100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ign_rst_wait", 64'(xreset_n), 64'(1));
    wait_to(v3 - 1);
    word_ready = 1'b0;
    wait_to(v3);
    chk("stall_first", 64'(word_data), 64'(rom_word(3)));
    bad = 0;
    for (int k = v3 + 1; k <= v3 + 48; k++) begin
      wait_to(k);
      start = (k == v3 + 10);
      if (word_valid !== 1'b1 || word_data !== rom_word(3)) bad++;
    end
    start = 1'b0;
    chk("stall_hold", 64'(bad), 64'(0));
    wait_to(v3 + 49);
    word_ready = 1'b1;
    wait_to(v3 + 49 + 12 * PER + 1);
    chk("stall_done", 64'(done), 64'(1));
    chk("stall_sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic seq_reset_mid();
    int v7;
    v7 = 2202 + 7 * PER;
    for (int i = 0; i < 7; i++) sb.push_back('{data: rom_word(i), cyc: 2202 + PER * i});
    start_seq();
    wait_to(v7 - 1);
    word_ready = 1'b0;
    wait_to(v7 + 2);
    chk("w7_present", 64'(word_data), 64'(rom_word(7)));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(word_valid), 64'(0));
    chk("rst_mid_xrst", 64'(xreset_n), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_data", 64'(word_data), 64'(0));
    chk("rst_mid_addr", 64'(rom_addr), 64'(0));
    chk("rst_mid_sb", 64'(sb.size()), 64'(0));
    sb.delete();
    reset      = 1'b0;
    word_ready = 1'b1;
    run_timed();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_xrst", 64'(xreset_n), 64'(0));
    chk("rst_valid", 64'(word_valid), 64'(0));
    chk("rst_data", 64'(word_data), 64'(0));
    chk("rst_addr", 64'(rom_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_xrst", 64'(xreset_n), 64'(0));
    run_timed();
    seq_stall();
    seq_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
